// File: rtl/dnn_wr_packer_if.sv
// DMA write-side bundle: write-control request plus 64-bit write-channel beats.
interface dnn_wr_packer_if;
    logic        wr_ctrl_valid;
    logic        wr_ctrl_ready;
    logic [31:0] wr_ctrl_index;
    logic [31:0] wr_ctrl_length;
    logic [2:0]  wr_ctrl_size;
    logic        wr_chnl_valid;
    logic        wr_chnl_ready;
    logic [63:0] wr_chnl_data;

    // Packer side drives requests and beats.
    modport master (
        output wr_ctrl_valid, wr_ctrl_index, wr_ctrl_length, wr_ctrl_size,
        output wr_chnl_valid, wr_chnl_data,
        input  wr_ctrl_ready, wr_chnl_ready
    );

    // DMA side accepts them.
    modport slave (
        input  wr_ctrl_valid, wr_ctrl_index, wr_ctrl_length, wr_ctrl_size,
        input  wr_chnl_valid, wr_chnl_data,
        output wr_ctrl_ready, wr_chnl_ready
    );
endinterface

// File: rtl/dnn_wr_packer.sv
// Captures the un-throttled 32-bit result stream into a FIFO, packs word pairs into
// 64-bit beats and drives the DMA write-control and write-channel handshakes.
module dnn_wr_packer #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [31:0]     cfg_num_out_i,
    input  logic [31:0]     cfg_wr_index_i,
    input  logic [31:0]     in_data_i,
    input  logic            in_en_i,
    dnn_wr_packer_if.master wr_if,
    output logic            busy_o,
    output logic            done_o,
    output logic            overflow_o,
    output logic [31:0]     debug_o
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCtrl = 2'd1,
        StData = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     num_out_q, num_out_d;
    logic [31:0]     wr_index_q, wr_index_d;
    logic [31:0]     length_q, length_d;
    logic [31:0]     words_in_q, words_in_d;
    logic [31:0]     beats_out_q, beats_out_d;
    logic [31:0]     beats_formed_q, beats_formed_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic            beat_valid_q, beat_valid_d;
    logic [63:0]     beat_data_q, beat_data_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     mem_q [Depth];

    logic                  start_accept;
    logic                  cap_active;
    logic                  in_take;
    logic                  push;
    logic                  drop;
    logic [PtrW-1:0]       count;
    logic                  fifo_full;
    logic                  has_one;
    logic                  has_two;
    logic                  need_one;
    logic                  all_in;
    logic                  beat_fire;
    logic                  beat_load;
    logic                  pop_two;
    logic                  pop_one;
    logic [1:0]            pop_n;
    logic [DEPTH_LOG2-1:0] rd_idx0;
    logic [DEPTH_LOG2-1:0] rd_idx1;
    logic [31:0]           lo_word;
    logic [31:0]           hi_word;

    // Datapath decode: capture, FIFO occupancy and beat formation.
    always_comb begin
        start_accept = (state_q == StIdle) && start_i;
        cap_active   = (state_q == StCtrl) || (state_q == StData);
        count        = wptr_q - rptr_q;
        fifo_full    = (count == PtrW'(Depth));
        has_one      = (count != '0);
        has_two      = (count >= PtrW'(2));
        // The final beat of an odd-length run carries only one real word.
        need_one     = (beats_formed_q == length_q - 32'd1) && num_out_q[0];
        // Once every word has arrived, a short FIFO means words were dropped: zero-fill.
        all_in       = (words_in_q == num_out_q);
        beat_fire    = beat_valid_q && wr_if.wr_chnl_ready;
        beat_load    = (state_q == StData) && (!beat_valid_q || beat_fire) &&
                       (beats_formed_q < length_q) &&
                       ((need_one ? has_one : has_two) || all_in);
        pop_two      = beat_load && !need_one && has_two;
        pop_one      = beat_load && has_one && !pop_two;
        pop_n        = pop_two ? 2'd2 : (pop_one ? 2'd1 : 2'd0);
        in_take      = cap_active && in_en_i && (words_in_q < num_out_q);
        // A pop in the same cycle frees room, so a push into a full FIFO still lands.
        push         = in_take && (!fifo_full || (pop_n != 2'd0));
        drop         = in_take && !push;
        rd_idx0      = rptr_q[DEPTH_LOG2-1:0];
        rd_idx1      = rd_idx0 + DEPTH_LOG2'(1);
        lo_word      = has_one ? mem_q[rd_idx0] : 32'd0;
        hi_word      = pop_two ? mem_q[rd_idx1] : 32'd0;
    end

    // Next-state for configuration, counters, FIFO pointers and the beat register.
    always_comb begin
        num_out_d      = num_out_q;
        wr_index_d     = wr_index_q;
        length_d       = length_q;
        words_in_d     = words_in_q;
        beats_out_d    = beats_out_q;
        beats_formed_d = beats_formed_q;
        wptr_d         = wptr_q;
        rptr_d         = rptr_q;
        beat_valid_d   = beat_valid_q;
        beat_data_d    = beat_data_q;
        overflow_d     = overflow_q;
        if (start_accept) begin
            num_out_d      = cfg_num_out_i;
            wr_index_d     = cfg_wr_index_i;
            // ceil(n/2) without a 33-bit intermediate: 0xFFFFFFFF -> 0x80000000.
            length_d       = {1'b0, cfg_num_out_i[31:1]} + {31'd0, cfg_num_out_i[0]};
            words_in_d     = '0;
            beats_out_d    = '0;
            beats_formed_d = '0;
            wptr_d         = '0;
            rptr_d         = '0;
            beat_valid_d   = 1'b0;
            overflow_d     = 1'b0;
        end else begin
            if (in_take) begin
                words_in_d = words_in_q + 32'd1;
            end
            if (push) begin
                wptr_d = wptr_q + PtrW'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
            rptr_d = rptr_q + PtrW'(pop_n);
            if (beat_load) begin
                beat_valid_d   = 1'b1;
                beat_data_d    = {hi_word, lo_word};
                beats_formed_d = beats_formed_q + 32'd1;
            end else if (beat_fire) begin
                beat_valid_d = 1'b0;
            end
            if (beat_fire) begin
                beats_out_d = beats_out_q + 32'd1;
            end
        end
    end

    // Control FSM next-state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (cfg_num_out_i == 32'd0) ? StDone : StCtrl;
                end
            end
            StCtrl: begin
                if (wr_if.wr_ctrl_ready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (beat_fire && (beats_out_q == length_q - 32'd1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            num_out_q      <= '0;
            wr_index_q     <= '0;
            length_q       <= '0;
            words_in_q     <= '0;
            beats_out_q    <= '0;
            beats_formed_q <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            beat_valid_q   <= 1'b0;
            beat_data_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_out_q      <= num_out_d;
            wr_index_q     <= wr_index_d;
            length_q       <= length_d;
            words_in_q     <= words_in_d;
            beats_out_q    <= beats_out_d;
            beats_formed_q <= beats_formed_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            beat_valid_q   <= beat_valid_d;
            beat_data_q    <= beat_data_d;
            overflow_q     <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care until the write pointer covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[DEPTH_LOG2-1:0]] <= in_data_i;
        end
    end

    // Outputs.
    always_comb begin
        wr_if.wr_ctrl_valid  = (state_q == StCtrl);
        wr_if.wr_ctrl_index  = wr_index_q;
        wr_if.wr_ctrl_length = length_q;
        wr_if.wr_ctrl_size   = (state_q == StCtrl) ? 3'd3 : 3'd0;
        wr_if.wr_chnl_valid  = beat_valid_q;
        wr_if.wr_chnl_data   = beat_data_q;
        busy_o               = (state_q != StIdle);
        done_o               = (state_q == StDone);
        overflow_o           = overflow_q;
        debug_o              = {30'd0, state_q};
    end

endmodule

// File: tb/tb_dnn_wr_packer.sv
// Randomised and directed bench for dnn_wr_packer against a word-list reference model.
module tb_dnn_wr_packer;

    localparam int unsigned DL    = 4;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cfg_num = '0;
    logic [31:0] cfg_idx = '0;
    logic [31:0] in_data = '0;
    logic        in_en = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] debug;

    dnn_wr_packer_if ifc ();

    dnn_wr_packer #(.DEPTH_LOG2(DL)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .cfg_num_out_i  (cfg_num),
        .cfg_wr_index_i (cfg_idx),
        .in_data_i      (in_data),
        .in_en_i        (in_en),
        .wr_if          (ifc.master),
        .busy_o         (busy),
        .done_o         (done),
        .overflow_o     (overflow),
        .debug_o        (debug)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] exp_q [$];
    logic [63:0] cap_q [$];
    logic [31:0] run_words [$];
    logic [31:0] exp_len = '0;
    logic [31:0] exp_idx = '0;
    int          done_cnt = 0;
    int          ctrl_cycles = 0;
    bit          ctrl_hold = 1'b0;
    bit          ctrl_rand = 1'b0;
    int          chnl_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beats: words in arrival order, paired low-first; only the first DEPTH words
    // survive when nothing drains during capture, the rest and any odd tail read as zero.
    task automatic build_exp(input logic [31:0] num);
        int          n;
        int          stored;
        logic [32:0] t;
        logic [31:0] lo;
        logic [31:0] hi;
        n      = int'(num);
        stored = (n < DEPTH) ? n : DEPTH;
        exp_q.delete();
        cap_q.delete();
        for (int b = 0; b < (n + 1) / 2; b++) begin
            lo = (2 * b < stored) ? run_words[2 * b] : 32'd0;
            hi = (2 * b + 1 < stored) ? run_words[2 * b + 1] : 32'd0;
            exp_q.push_back({hi, lo});
        end
        t       = {1'b0, num} + 33'd1;
        exp_len = t[32:1];
    endtask

    // Ready generators for the DMA side.
    initial begin
        int pc;
        pc = 0;
        ifc.wr_ctrl_ready = 1'b0;
        ifc.wr_chnl_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pc++;
            ifc.wr_ctrl_ready = ctrl_hold ? 1'b0 :
                                (ctrl_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            case (chnl_mode)
                0:       ifc.wr_chnl_ready = 1'b1;
                1:       ifc.wr_chnl_ready = 1'($urandom_range(0, 1));
                default: ifc.wr_chnl_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
            endcase
        end
    end

    // Per-cycle compare against the expected beat queue and handshake rules.
    initial begin
        bit          hold_pend;
        bit          prev_ctrl_hs;
        logic [63:0] held;
        hold_pend    = 1'b0;
        prev_ctrl_hs = 1'b0;
        held         = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_pend    = 1'b0;
                prev_ctrl_hs = 1'b0;
            end else begin
                if (prev_ctrl_hs) chk("ctrl_valid_falls", ifc.wr_ctrl_valid, 0);
                prev_ctrl_hs = ifc.wr_ctrl_valid && ifc.wr_ctrl_ready;
                if (ifc.wr_ctrl_valid) begin
                    ctrl_cycles++;
                    chk("ctrl_index", ifc.wr_ctrl_index, exp_idx);
                    chk("ctrl_length", ifc.wr_ctrl_length, exp_len);
                    chk("ctrl_size", ifc.wr_ctrl_size, 3);
                end
                chk("busy_vs_state", busy, debug != 0);
                if (hold_pend) begin
                    chk("beat_held_valid", ifc.wr_chnl_valid, 1);
                    chk("beat_held_data", ifc.wr_chnl_data, held);
                end
                hold_pend = 1'b0;
                if (ifc.wr_chnl_valid) begin
                    if (ifc.wr_chnl_ready) begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL extra_beat: got %h expected no beat", ifc.wr_chnl_data);
                        end else begin
                            chk("beat_data", ifc.wr_chnl_data, exp_q.pop_front());
                        end
                        cap_q.push_back(ifc.wr_chnl_data);
                    end else begin
                        hold_pend = 1'b1;
                        held      = ifc.wr_chnl_data;
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    // One complete transfer of run_words[0 .. num-1].
    task automatic run(input logic [31:0] num, input logic [31:0] idx, input int gap_pct,
                       input bit hold, input bit extra);
        bit seen;
        bit precise;
        build_exp(num);
        exp_idx     = idx;
        done_cnt    = 0;
        ctrl_cycles = 0;
        ctrl_hold   = hold;
        // Words while idle must not be captured.
        in_en   = 1'b1;
        in_data = 32'hDEAD_BEEF;
        tick();
        in_en   = 1'b0;
        start   = 1'b1;
        cfg_num = num;
        cfg_idx = idx;
        tick();
        start   = 1'b0;
        cfg_num = $urandom;
        cfg_idx = $urandom;
        @(negedge clk);
        chk("ctrl_valid_cycle1", ifc.wr_ctrl_valid, num != 0);
        chk("overflow_cleared", overflow, 0);
        seen    = 1'b0;
        precise = 1'b0;
        if (num == 0) begin
            chk("done_cycle1", done, 1);
            seen    = 1'b1;
            precise = 1'b1;
        end
        for (int i = 0; i < int'(num); i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_en = 1'b0;
                tick();
            end
            in_en   = 1'b1;
            in_data = run_words[i];
            tick();
        end
        if (extra && num != 0) begin
            for (int i = 0; i < 3; i++) begin
                in_en   = 1'b1;
                in_data = $urandom;
                tick();
            end
        end
        in_en     = 1'b0;
        ctrl_hold = 1'b0;
        if (done_cnt > 0) seen = 1'b1;
        for (int t = 0; t < 4000 && !seen; t++) begin
            @(negedge clk);
            if (done) begin
                seen    = 1'b1;
                precise = 1'b1;
            end
        end
        chk("done_seen", seen, 1);
        if (precise) begin
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            chk("done_single_cycle", done, 0);
        end
        repeat (2) @(negedge clk);
        chk("done_pulse_count", done_cnt, 1);
        chk("beats_remaining", exp_q.size(), 0);
        chk("overflow_final", overflow, num > DEPTH);
        chk("idle_after_run", busy, 0);
        if (num == 0) chk("no_ctrl_for_zero", ctrl_cycles, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl_valid"}, ifc.wr_ctrl_valid, 0);
        chk({tag, "_ctrl_index"}, ifc.wr_ctrl_index, 0);
        chk({tag, "_ctrl_length"}, ifc.wr_ctrl_length, 0);
        chk({tag, "_ctrl_size"}, ifc.wr_ctrl_size, 0);
        chk({tag, "_chnl_valid"}, ifc.wr_chnl_valid, 0);
        chk({tag, "_chnl_data"}, ifc.wr_chnl_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_debug"}, debug, 0);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] num;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // Four consecutive words, always ready.
        chnl_mode = 0;
        ctrl_rand = 1'b0;
        run_words = '{32'h11, 32'h22, 32'h33, 32'h44};
        run(32'd4, 32'h0000_0100, 0, 1'b0, 1'b0);
        chk("d4_beat_count", cap_q.size(), 2);
        chk("d4_beat0", cap_q[0], 64'h0000_0022_0000_0011);
        chk("d4_beat1", cap_q[1], 64'h0000_0044_0000_0033);

        // Odd count: final beat zero in the upper half.
        run_words = '{32'hA, 32'hB, 32'hC};
        run(32'd3, 32'h0000_0200, 0, 1'b0, 1'b1);
        chk("d3_beat_count", cap_q.size(), 2);
        chk("d3_beat0", cap_q[0], 64'h0000_000B_0000_000A);
        chk("d3_beat1", cap_q[1], 64'h0000_0000_0000_000C);

        // Channel ready toggling 1,0,0,1.
        chnl_mode = 2;
        run_words.delete();
        for (int i = 0; i < 8; i++) run_words.push_back($urandom);
        run(32'd8, 32'h0000_0300, 0, 1'b0, 1'b0);
        chk("d8_beat_count", cap_q.size(), 4);

        // Zero-length run.
        chnl_mode = 0;
        run_words.delete();
        run(32'd0, 32'h0000_0400, 0, 1'b0, 1'b0);

        // Overflow: control held off while 20 words arrive into a 16-word FIFO.
        run_words.delete();
        for (int i = 0; i < 20; i++) run_words.push_back(32'(i + 1));
        run(32'd20, 32'h0000_0500, 0, 1'b1, 1'b0);
        chk("ovf_beat_count", cap_q.size(), 10);
        chk("ovf_beat7", cap_q[7], 64'h0000_0010_0000_000F);
        chk("ovf_beat8", cap_q[8], 64'h0);
        chk("ovf_beat9", cap_q[9], 64'h0);

        // A following run starts with overflow cleared.
        run_words.delete();
        for (int i = 0; i < 5; i++) run_words.push_back($urandom);
        run(32'd5, 32'h0000_0600, 20, 1'b0, 1'b0);

        // Maximum count: length saturates into bit 31; abort with reset.
        ctrl_hold = 1'b1;
        exp_len   = 32'h8000_0000;
        exp_idx   = 32'h0000_0700;
        tick();
        start   = 1'b1;
        cfg_num = 32'hFFFF_FFFF;
        cfg_idx = 32'h0000_0700;
        tick();
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("max_ctrl_valid", ifc.wr_ctrl_valid, 1);
        chk("max_length", ifc.wr_ctrl_length, 32'h8000_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("abort_ctrl");
        tick();
        rst       = 1'b1;
        ctrl_hold = 1'b0;

        // Reset in the middle of a four-beat transfer.
        run_words.delete();
        for (int i = 0; i < 8; i++) run_words.push_back($urandom);
        build_exp(32'd8);
        exp_idx = 32'h0000_0800;
        tick();
        start   = 1'b1;
        cfg_num = 32'd8;
        cfg_idx = 32'h0000_0800;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_en   = 1'b1;
            in_data = run_words[i];
            tick();
            if (cap_q.size() != 0) break;
        end
        in_en = 1'b0;
        for (int t = 0; t < 200 && cap_q.size() == 0; t++) @(negedge clk);
        chk("first_beat_before_reset", cap_q.size() >= 1, 1);
        chk("still_in_data", debug, 2);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("abort_data");
        tick();
        rst = 1'b1;
        exp_q.delete();
        run_words.delete();
        for (int i = 0; i < 4; i++) run_words.push_back($urandom);
        run(32'd4, 32'h0000_0900, 0, 1'b0, 1'b0);
        chk("post_reset_beats", cap_q.size(), 2);

        // Random runs within FIFO capacity, random gaps and readiness.
        chnl_mode = 1;
        ctrl_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            num = 32'($urandom_range(1, DEPTH));
            run_words.delete();
            for (int i = 0; i < int'(num); i++) run_words.push_back($urandom);
            run(num, $urandom, 30, 1'b0, 1'((r % 2) == 1));
            chk("rand_beat_count", cap_q.size(), (num + 1) / 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
